// File: rtl/cdm_seq_divider_if.sv
// Handshake bundle for cdm_seq_divider: operand request (N/D) and result
// response (Q/dz) each with their own valid/ready pair.
// Optional macro CDM_DIV_REM_EN adds the remainder output R.
interface cdm_seq_divider_if #(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH_N-1:0] N;
    logic [WIDTH_D-1:0] D;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH_N-1:0] Q;
    logic               dz;
`ifdef CDM_DIV_REM_EN
    logic [WIDTH_D-1:0] R;
`endif

    // Requester/consumer side: presents operands, accepts results.
    modport master (
        output in_valid,
        output N,
        output D,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Q,
`ifdef CDM_DIV_REM_EN
        input  R,
`endif
        input  dz
    );

    // Divider side.
    modport slave (
        input  in_valid,
        input  N,
        input  D,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Q,
`ifdef CDM_DIV_REM_EN
        output R,
`endif
        output dz
    );
endinterface

// File: rtl/cdm_seq_divider.sv
// cdm_seq_divider: sequential restoring divider, WIDTH_N-bit dividend by
// WIDTH_D-bit divisor, one quotient bit per clock. Recovers a multiplier
// operand from a product and the other operand.
// Timing: accept at edge 0, out_valid after edge WIDTH_N+1; a zero divisor
// skips the iteration and raises out_valid after edge 1 with Q all-ones, dz=1.
// Optional macro CDM_DIV_REM_EN exposes the final remainder on R.
module cdm_seq_divider #(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    cdm_seq_divider_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH_N + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH_N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH_N-1:0] acc;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH_D-1:0] rem;      // partial remainder, always < divisor
    logic [WIDTH_D-1:0] d_reg;
    logic               out_valid_q;
    logic [WIDTH_N-1:0] q_reg;
    logic               dz_reg;
`ifdef CDM_DIV_REM_EN
    logic [WIDTH_D-1:0] r_reg;
`endif

    logic [WIDTH_D:0]   shifted;
    logic [WIDTH_D+1:0] trial;
    logic               fits;
    logic [WIDTH_D:0]   rem_nxt;
    logic               load_result;
    logic               unused_rem_msb;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.Q         = q_reg;
    assign bus.dz        = dz_reg;
`ifdef CDM_DIV_REM_EN
    assign bus.R         = r_reg;
`endif

    // Results are registered on the first DONE cycle so both the normal and
    // the divide-by-zero path share one output load point.
    assign load_result = (state == DONE) && !out_valid_q;

    // One restoring step: shift in the next dividend bit, trial-subtract D.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        shifted = {rem, acc[WIDTH_N-1]};
        trial   = {1'b0, shifted} - {2'b00, d_reg};
        fits    = !trial[WIDTH_D+1];
        rem_nxt = fits ? trial[WIDTH_D:0] : shifted;
    end

    // The kept or restored value is below D, so its top bit is always zero.
    assign unused_rem_msb = rem_nxt[WIDTH_D];

    // Control: state transitions and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state updates use <= so all registers see pre-edge values.
            state       <= IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cnt   <= '0;
                        state <= (bus.D == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Datapath: operand capture on accept and one shift/subtract per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too so an aborted division leaves no stale state.
            acc   <= '0;
            rem   <= '0;
            d_reg <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            d_reg <= bus.D;
            if (bus.D == '0) begin
                acc <= '1;
                rem <= bus.N[WIDTH_D-1:0];
            end else begin
                acc <= bus.N;
                rem <= '0;
            end
        end else if (state == CALC) begin
            acc <= {acc[WIDTH_N-2:0], fits};
            rem <= rem_nxt[WIDTH_D-1:0];
        end
    end

    // Result registers: loaded once per operation, held through backpressure
    // and after the handshake until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg  <= '0;
            dz_reg <= 1'b0;
        end else if (load_result) begin
            q_reg  <= acc;
            dz_reg <= (d_reg == '0);
        end
    end

`ifdef CDM_DIV_REM_EN
    // Remainder output shares the load point of Q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg <= '0;
        end else if (load_result) begin
            r_reg <= rem;
        end
    end
`endif

endmodule

// File: doc/cdm_seq_divider.md
Name: cdm_seq_divider

Overview:
- Sequential restoring divider, 16-bit dividend by 8-bit divisor; the inverse operation of the 8x8 carry-disregard multiplier datapath.
- Recovers an operand from a 16-bit product and the other 8-bit operand.
- Used by the characterisation harness to check approximate-multiplier products against operands, and as a general divide unit beside the multiplier.
- Valid/ready on input and output; one quotient bit per clock.

Parameters:
- WIDTH_N, 16, dividend and quotient width
- WIDTH_D, 8, divisor and remainder width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  N and D are presented
- in_ready  output  1  block can accept an operation
- N  input  WIDTH_N  dividend (multiplier product)
- D  input  WIDTH_D  divisor (known multiplier operand)
- out_valid  output  1  result held on Q/dz
- out_ready  input  1  consumer accepts the result
- Q  output  WIDTH_N  quotient
- dz  output  1  divide-by-zero flag for the current result

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, Q=0, dz=0.
  - Internal partial remainder, shift register and counter are cleared.
- States:
  - IDLE -> CALC on in_valid&&in_ready when D!=0.
  - IDLE -> DONE on in_valid&&in_ready when D==0.
  - CALC -> DONE when the counter reaches WIDTH_N.
  - DONE -> IDLE on out_valid&&out_ready.
- in_ready is 1 only in IDLE. N and D are captured on the accept edge; later changes on N/D are ignored.
- CALC step, one per clock, WIDTH_N steps:
  - Shift the partial remainder (WIDTH_D+1 bits) left, bringing in the next dividend MSB.
  - Trial-subtract D.
  - If the result is non-negative, keep it and shift 1 into the quotient; otherwise restore and shift 0.
- Latency:
  - Accept at edge 0; out_valid=1 after edge WIDTH_N+1 (17 clocks for the defaults).
  - Divide-by-zero: out_valid=1 after edge 1.
- Divide-by-zero result: Q={WIDTH_N{1'b1}}, dz=1; the remainder equals N[WIDTH_D-1:0].
- Normal result: dz=0.
- Result is exact integer division: Q=floor(N/D); remainder R=N-Q*D < D.
- Output hold:
  - In DONE, out_valid, Q and dz stay constant until the out_ready handshake.
  - If out_ready is already 1 when out_valid rises, the handshake completes on that edge.
- IDLE is entered on the handshake edge:
  - in_ready=1 the next cycle; no same-cycle accept in DONE.
  - out_valid drops to 0; Q and dz keep their last value.
- Boundary cases:
  - N=0 gives Q=0.
  - D=1 gives Q=N.
  - N<D gives Q=0.
  - Max operands 16'hFFFF/8'hFF give Q=16'h0101.
- in_valid during CALC or DONE is ignored; no queueing.
- rst_n asserted mid-CALC or in DONE aborts immediately; the partial result is discarded and all outputs return to reset values.

Optional Feature:
- Macro: CDM_DIV_REM_EN.
- With the macro defined:
  - Extra output port R, WIDTH_D bits, carries the final remainder.
  - R is valid and held with Q while out_valid=1, and resets to 0.
  - On divide-by-zero, R=N[WIDTH_D-1:0].
- Without the macro:
  - No R port.
  - The remainder register is internal only; synthesis may trim it.
  - All other behaviour is identical.

Test Plan:
- Reset, then N=16'd221, D=8'd13, out_ready=1:
  - in_ready drops the cycle after accept.
  - out_valid=1 after edge 17 with Q=17, dz=0; R=0 under CDM_DIV_REM_EN.
- N=16'hFFFF, D=8'hFF -> Q=16'h0101, dz=0; R=0 under CDM_DIV_REM_EN.
- N=16'd100, D=8'd7 -> Q=14; R=2 under CDM_DIV_REM_EN.
- N=16'd100, D=8'd200 -> Q=0; R=100 under CDM_DIV_REM_EN.
- N=16'h1234, D=0:
  - out_valid after edge 1 with Q=16'hFFFF, dz=1; R=8'h34 under CDM_DIV_REM_EN.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> Q and dz stable, in_ready=0. Raise out_ready -> handshake, then IDLE with in_ready=1 the next cycle.
- Mid-operation inputs: toggle in_valid, N and D during CALC -> no effect on the result.
- Reset mid-operation: assert rst_n=0 at CALC step 8 -> out_valid=0, Q=0, in_ready=1 immediately. A fresh N=16'd50, D=8'd5 then yields Q=10.
